sop_seq_mac: RTL and testbench

- Parametrised sequential sum-of-products unit for the board labs. Computes R = sum over i of A[i]*B[i], for N operand pairs of W bits each.
- Operands load through an edge-detected write port (switch/key driven) into a register file.
- A start edge launches a shift-add multiply-accumulate FSM, which reports busy/done and an overflow flag.
- A display mux feeds the seven-segment path with either the selected operand pair or the result.

---
 rtl/sop_seq_mac_if.sv | 32 +++
 rtl/sop_seq_mac.sv | 246 ++++++++++++++++++++++++
 tb/tb_sop_seq_mac.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/sop_seq_mac_if.sv
// Operand-load, control and display bus of the sequential sum-of-products unit.
// The master drives operands/controls; the slave (sop_seq_mac) returns status, result and display word.
interface sop_seq_mac_if #(
  parameter int W = 8,
  parameter int N = 2
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam int RW = 2 * W + CW;
  localparam int IW = (N > 2) ? $clog2(N) : 1;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic          wr_op;
  logic [W-1:0]  wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          ovf;
  logic          disp_mode;
  logic [2*W-1:0] disp_value;

  modport master (
    output wr_en, wr_idx, wr_op, wr_data, start, disp_mode,
    input  busy, done, result, ovf, disp_value
  );

  modport slave (
    input  wr_en, wr_idx, wr_op, wr_data, start, disp_mode,
    output busy, done, result, ovf, disp_value
  );
endinterface

// File: rtl/sop_seq_mac.sv
// Sequential shift-add sum-of-products R = sum A[i]*B[i] with edge-detected operand writes and display mux.
// Optional macro SOP_SIGNED_EN switches operands, accumulator and overflow check to two's complement.
module sop_seq_mac #(
  parameter int W = 8,
  parameter int N = 2
) (
  input logic          clk,
  input logic          rst_n,
  sop_seq_mac_if.slave bus
);
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam int RW = 2 * W + CW;
  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam int BW = $clog2(W);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_MUL  = 3'd2;
  localparam logic [2:0] ST_ACC  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  logic [2:0]     wr_sync_r;
  logic [2:0]     start_sync_r;
  logic           wr_ev_s;
  logic           start_ev_s;
  logic           idx_ok_s;

  logic [W-1:0]   a_r [N];
  logic [W-1:0]   b_r [N];

  logic [2:0]     state_r;
  logic [2:0]     state_nx_s;
  logic [IW-1:0]  idx_r;
  logic [BW-1:0]  bitcnt_r;
  logic [2*W-1:0] mcand_r;
  logic [W-1:0]   mplier_r;
  logic [2*W-1:0] prod_r;
  logic [RW-1:0]  acc_r;
  logic [RW-1:0]  result_r;
  logic           ovf_r;
  logic           busy_r;
  logic           done_r;

  logic [W-1:0]   load_a_s;
  logic [W-1:0]   load_b_s;
  logic [RW-1:0]  addend_s;
  logic           ovf_s;
  logic [2*W-1:0] disp_s;

  // Two-flop synchronisers; bit 2 is the previous synchronised level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync_r    <= 3'b000;
      start_sync_r <= 3'b000;
    end else begin
      wr_sync_r    <= {wr_sync_r[1:0], bus.wr_en};
      start_sync_r <= {start_sync_r[1:0], bus.start};
    end
  end

  assign wr_ev_s    = wr_sync_r[1] & ~wr_sync_r[2];
  assign start_ev_s = start_sync_r[1] & ~start_sync_r[2];

  // Index range check written as a match loop so non-power-of-two N rejects unused codes
  always_comb begin
    idx_ok_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (bus.wr_idx == IW'(i)) begin
        idx_ok_s = 1'b1;
      end else begin
        idx_ok_s = idx_ok_s;
      end
    end
  end

`ifdef SOP_SIGNED_EN
  logic sign_r;

  function automatic logic [W-1:0] mag_f(input logic [W-1:0] v);
    if (v[W-1]) begin
      mag_f = ~v + W'(1);
    end else begin
      mag_f = v;
    end
  endfunction

  // Signed operand magnitudes, negated product add and two's complement range check
  always_comb begin
    load_a_s = mag_f(a_r[idx_r]);
    load_b_s = mag_f(b_r[idx_r]);
    if (sign_r) begin
      addend_s = ~{{CW{1'b0}}, prod_r} + RW'(1);
    end else begin
      addend_s = {{CW{1'b0}}, prod_r};
    end
    ovf_s = ~((&acc_r[RW-1:2*W-1]) | ~(|acc_r[RW-1:2*W-1]));
  end

  // Product sign captured alongside the magnitudes in LOAD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r <= 1'b0;
    end else if (state_r == ST_LOAD) begin
      sign_r <= a_r[idx_r][W-1] ^ b_r[idx_r][W-1];
    end else begin
      sign_r <= sign_r;
    end
  end
`else
  // Unsigned operands feed straight through; overflow is any bit above 2W
  always_comb begin
    load_a_s = a_r[idx_r];
    load_b_s = b_r[idx_r];
    addend_s = {{CW{1'b0}}, prod_r};
    ovf_s    = |acc_r[RW-1:2*W];
  end
`endif

  // Next-state logic of the multiply-accumulate sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_ev_s) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_LOAD: state_nx_s = ST_MUL;
      ST_MUL: begin
        if (bitcnt_r == BW'(W - 1)) begin
          state_nx_s = ST_ACC;
        end else begin
          state_nx_s = ST_MUL;
        end
      end
      ST_ACC: begin
        if (idx_r == IW'(N - 1)) begin
          state_nx_s = ST_DONE;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      ST_DONE: state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Operand register file; writes are only accepted while the sequencer is idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        a_r[i] <= {W{1'b0}};
        b_r[i] <= {W{1'b0}};
      end
    end else if (wr_ev_s && (state_r == ST_IDLE) && idx_ok_s) begin
      if (bus.wr_op) begin
        b_r[bus.wr_idx] <= bus.wr_data;
      end else begin
        a_r[bus.wr_idx] <= bus.wr_data;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        a_r[i] <= a_r[i];
        b_r[i] <= b_r[i];
      end
    end
  end

  // Sequencer state, shift-add datapath and registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      idx_r    <= {IW{1'b0}};
      bitcnt_r <= {BW{1'b0}};
      mcand_r  <= {(2*W){1'b0}};
      mplier_r <= {W{1'b0}};
      prod_r   <= {(2*W){1'b0}};
      acc_r    <= {RW{1'b0}};
      result_r <= {RW{1'b0}};
      ovf_r    <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      done_r  <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (start_ev_s) begin
            acc_r <= {RW{1'b0}};
            idx_r <= {IW{1'b0}};
          end else begin
            acc_r <= acc_r;
            idx_r <= idx_r;
          end
        end
        ST_LOAD: begin
          mcand_r  <= {{W{1'b0}}, load_a_s};
          mplier_r <= load_b_s;
          prod_r   <= {(2*W){1'b0}};
          bitcnt_r <= {BW{1'b0}};
        end
        ST_MUL: begin
          if (mplier_r[0]) begin
            prod_r <= prod_r + mcand_r;
          end else begin
            prod_r <= prod_r;
          end
          mcand_r  <= mcand_r << 1;
          mplier_r <= mplier_r >> 1;
          bitcnt_r <= bitcnt_r + BW'(1);
        end
        ST_ACC: begin
          acc_r <= acc_r + addend_s;
          idx_r <= idx_r + IW'(1);
        end
        ST_DONE: begin
          result_r <= acc_r;
          ovf_r    <= ovf_s;
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  // Display word: selected operand pair, or low 2W bits of the result
  always_comb begin
    if (bus.disp_mode) begin
      disp_s = result_r[2*W-1:0];
    end else if (idx_ok_s) begin
      disp_s = {a_r[bus.wr_idx], b_r[bus.wr_idx]};
    end else begin
      disp_s = {(2*W){1'b0}};
    end
  end

  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.result     = result_r;
  assign bus.ovf        = ovf_r;
  assign bus.disp_value = disp_s;
endmodule

// File: tb/tb_sop_seq_mac.sv
// Directed bench for sop_seq_mac (W=8, N=2): operand load, latency, overflow, held start,
// write-while-busy, mid-run reset, and the signed vectors when SOP_SIGNED_EN is defined.
module tb_sop_seq_mac;
  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   cyc;
  int   pulses;

  sop_seq_mac_if #(.W(8), .N(2)) bus ();

  sop_seq_mac #(.W(8), .N(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic write_op(input logic idx, input logic op, input logic [7:0] data);
    bus.wr_idx  = idx;
    bus.wr_op   = op;
    bus.wr_data = data;
    bus.wr_en   = 1'b1;
    repeat (3) tick();
    bus.wr_en = 1'b0;
    repeat (3) tick();
  endtask

  task automatic load4(input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] a1, input logic [7:0] b1);
    write_op(1'b0, 1'b0, a0);
    write_op(1'b0, 1'b1, b0);
    write_op(1'b1, 1'b0, a1);
    write_op(1'b1, 1'b1, b1);
  endtask

  // Waits for done up to tick 60 after the start drive; returns the tick it appeared on, or 0
  task automatic wait_done(input int first, output int at);
    at = 0;
    for (int k = first; k <= 60; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        at = k;
        break;
      end
    end
  endtask

  task automatic run_check(input string tag, input logic [16:0] exp_res, input logic exp_ovf);
    int at;
    bus.start = 1'b1;
    tick();
    tick();
    chk({tag, "_busy_event_cycle"}, {31'd0, bus.busy}, 32'd0);
    tick();
    chk({tag, "_busy_rise"}, {31'd0, bus.busy}, 32'd1);
    wait_done(4, at);
    chk({tag, "_done_tick"}, at, 32'd23);
    bus.start = 1'b0;
    tick();
    chk({tag, "_done_pulse_width"}, {31'd0, bus.done}, 32'd0);
    chk({tag, "_result"}, {15'd0, bus.result}, {15'd0, exp_res});
    chk({tag, "_ovf"}, {31'd0, bus.ovf}, {31'd0, exp_ovf});
    repeat (3) tick();
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_idx    = 1'b0;
    bus.wr_op     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.start     = 1'b0;
    bus.disp_mode = 1'b0;
    repeat (2) tick();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {15'd0, bus.result}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst_disp", {16'd0, bus.disp_value}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic pair 3*4 + 5*6 = 42
    load4(8'd3, 8'd4, 8'd5, 8'd6);
    bus.wr_idx = 1'b1;
    #1;
    chk("disp_pair1", {16'd0, bus.disp_value}, 32'h0506);
    run_check("basic", 17'h0002A, 1'b0);
    bus.disp_mode = 1'b1;
    #1;
    chk("disp_result_basic", {16'd0, bus.disp_value}, 32'h002A);
    bus.disp_mode = 1'b0;

    // All ones: unsigned 2*0xFE01 overflows 16 bits; signed (-1)*(-1)*2 = 2
    load4(8'hFF, 8'hFF, 8'hFF, 8'hFF);
`ifdef SOP_SIGNED_EN
    run_check("allff", 17'h00002, 1'b0);
    bus.disp_mode = 1'b1;
    #1;
    chk("disp_result_allff", {16'd0, bus.disp_value}, 32'h0002);
`else
    run_check("allff", 17'h1FC02, 1'b1);
    bus.disp_mode = 1'b1;
    #1;
    chk("disp_result_allff", {16'd0, bus.disp_value}, 32'hFC02);
`endif
    bus.disp_mode = 1'b0;

    // Held start level: one run only
    pulses = 0;
    bus.start = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    chk("held_start_pulses", pulses, 32'd1);
    chk("held_start_idle", {31'd0, bus.busy}, 32'd0);
    bus.start = 1'b0;
    repeat (4) tick();

    // Write of A0 during pair-0 MUL must be dropped
    bus.start = 1'b1;
    repeat (4) tick();
    bus.start   = 1'b0;
    bus.wr_idx  = 1'b0;
    bus.wr_op   = 1'b0;
    bus.wr_data = 8'h10;
    bus.wr_en   = 1'b1;
    repeat (3) tick();
    bus.wr_en = 1'b0;
    wait_done(8, cyc);
    chk("busy_write_done_tick", cyc, 32'd23);
    tick();
`ifdef SOP_SIGNED_EN
    chk("busy_write_result", {15'd0, bus.result}, 32'h00002);
`else
    chk("busy_write_result", {15'd0, bus.result}, 32'h1FC02);
`endif
    bus.wr_idx = 1'b0;
    #1;
    chk("busy_write_a0_unchanged", {16'd0, bus.disp_value}, 32'hFFFF);
    repeat (3) tick();

    // Reset during pair-1 MUL: everything clears, no done pulse follows
    bus.start = 1'b1;
    repeat (4) tick();
    bus.start = 1'b0;
    repeat (12) tick();
    chk("pre_abort_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_result", {15'd0, bus.result}, 32'd0);
    chk("abort_ovf", {31'd0, bus.ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (bus.done === 1'b1) pulses++;
    end
    chk("abort_no_done", pulses, 32'd0);
    load4(8'd3, 8'd4, 8'd5, 8'd6);
    run_check("post_abort", 17'h0002A, 1'b0);

`ifdef SOP_SIGNED_EN
    // (-1)*2 + (-128)*1 = -130; then 4 * 0x80 gives +32768 which is out of signed 16-bit range
    load4(8'hFF, 8'h02, 8'h80, 8'h01);
    run_check("signed_neg", 17'h1FF7E, 1'b0);
    load4(8'h80, 8'h80, 8'h80, 8'h80);
    run_check("signed_ovf", 17'h08000, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
